// File: rtl/stream_width_converter.sv
// stream_width_converter
// Valid/ready gearbox between streams of different word widths.
// Downsize: one wide word is serialised into RATIO narrow beats.
// Upsize:   RATIO narrow beats are packed into one wide word; a word may
//           close early on in_last, in which case unfilled lanes read 0.
// Equal widths: a single register stage.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. Once out_valid is high, out_data/out_last/out_lanes hold
// until the transfer completes, and out_valid only drops after a transfer.
module stream_width_converter #(
    parameter int INPUT_WIDTH  = 64,
    parameter int OUTPUT_WIDTH = 32,
    parameter bit LSB_FIRST    = 1'b1,
    localparam int LANE_W = (INPUT_WIDTH < OUTPUT_WIDTH) ? INPUT_WIDTH : OUTPUT_WIDTH,
    localparam int MAX_W  = (INPUT_WIDTH < OUTPUT_WIDTH) ? OUTPUT_WIDTH : INPUT_WIDTH,
    localparam int RATIO  = MAX_W / LANE_W,
    localparam int CNT_W  = $clog2(RATIO + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [INPUT_WIDTH-1:0]  in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [OUTPUT_WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic [CNT_W-1:0]        out_lanes
);

    // Low during reset and for the first edge after it, so in_ready is 0
    // while rst_n is low and rises one cycle after deassertion.
    logic r_alive;

    // Track whether the block has seen a clock edge since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
        end
    end

    generate
        if ((MAX_W % LANE_W) != 0) begin : g_bad_ratio
            $error("stream_width_converter: larger width must be a multiple of the smaller width");
        end

        if (RATIO == 1) begin : g_pass
            logic [OUTPUT_WIDTH-1:0] r_data;
            logic                    r_valid;
            logic                    r_last;
            logic                    w_accept;

            assign in_ready  = r_alive && (!r_valid || out_ready);
            assign w_accept  = in_valid && in_ready;
            assign out_data  = r_data;
            assign out_valid = r_valid;
            assign out_last  = r_last;
            assign out_lanes = r_valid ? CNT_W'(1) : '0;

            // One register stage: load on accept, empty when the consumer takes it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                end else if (w_accept) begin
                    r_data  <= in_data;
                    r_valid <= 1'b1;
                    r_last  <= in_last;
                end else if (out_ready) begin
                    r_valid <= 1'b0;
                end
            end

        end else if (INPUT_WIDTH > OUTPUT_WIDTH) begin : g_down
            localparam logic [0:0] S_EMPTY = 1'b0;
            localparam logic [0:0] S_SEND  = 1'b1;

            logic [0:0]             r_state;
            logic [INPUT_WIDTH-1:0] r_word;
            logic                   r_last;
            logic [CNT_W-1:0]       r_beat;
            logic                   w_last_beat;
            logic                   w_out_valid;
            logic                   w_accept;
            logic                   w_out_xfer;
            logic [CNT_W-1:0]       w_lane_idx;
            logic [LANE_W-1:0]      w_lane;

            assign w_last_beat = (r_beat == CNT_W'(RATIO - 1));
            assign w_out_valid = (r_state == S_SEND);
            // A new word may enter while the final lane of the current one
            // leaves, which keeps the output busy every cycle.
            assign in_ready    = r_alive && ((r_state == S_EMPTY) || (w_last_beat && out_ready));
            assign w_accept    = in_valid && in_ready;
            assign w_out_xfer  = w_out_valid && out_ready;
            assign w_lane_idx  = LSB_FIRST ? r_beat : (CNT_W'(RATIO - 1) - r_beat);

            // Select the lane currently being sent.
            always_comb begin
                w_lane = '0;
                for (int k = 0; k < RATIO; k++) begin
                    if (w_lane_idx == CNT_W'(k)) begin
                        w_lane = r_word[k*LANE_W +: LANE_W];
                    end
                end
            end

            assign out_data  = w_lane;
            assign out_valid = w_out_valid;
            assign out_last  = w_out_valid && r_last && w_last_beat;
            assign out_lanes = w_out_valid ? CNT_W'(1) : '0;

            // EMPTY/SEND sequencing and beat counter.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state <= S_EMPTY;
                    r_word  <= '0;
                    r_last  <= 1'b0;
                    r_beat  <= '0;
                end else if (w_accept) begin
                    r_state <= S_SEND;
                    r_word  <= in_data;
                    r_last  <= in_last;
                    r_beat  <= '0;
                end else if (w_out_xfer) begin
                    if (w_last_beat) begin
                        r_state <= S_EMPTY;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
            end

        end else begin : g_up
            localparam logic [0:0] S_FILL = 1'b0;
            localparam logic [0:0] S_FULL = 1'b1;

            logic [0:0]              r_state;
            logic [OUTPUT_WIDTH-1:0] r_word;
            logic                    r_last;
            logic [CNT_W-1:0]        r_fill;
            logic                    w_out_valid;
            logic                    w_accept;
            logic                    w_out_xfer;
            logic [CNT_W-1:0]        w_pos_cnt;
            logic [CNT_W-1:0]        w_fill_next;
            logic [CNT_W-1:0]        w_lane_idx;
            logic [OUTPUT_WIDTH-1:0] w_word_next;

            assign w_out_valid = (r_state == S_FULL);
            assign in_ready    = r_alive && ((r_state == S_FILL) || out_ready);
            assign w_accept    = in_valid && in_ready;
            assign w_out_xfer  = w_out_valid && out_ready;
            // An accept while FULL coincides with the output transfer, so the
            // incoming beat starts a fresh word at lane 0.
            assign w_pos_cnt   = w_out_valid ? '0 : r_fill;
            assign w_fill_next = w_pos_cnt + 1'b1;
            assign w_lane_idx  = LSB_FIRST ? w_pos_cnt : (CNT_W'(RATIO - 1) - w_pos_cnt);

            // Merge the incoming beat into its lane; a fresh word starts all-zero.
            always_comb begin
                w_word_next = w_out_valid ? '0 : r_word;
                for (int k = 0; k < RATIO; k++) begin
                    if (w_lane_idx == CNT_W'(k)) begin
                        w_word_next[k*LANE_W +: LANE_W] = in_data;
                    end
                end
            end

            assign out_data  = r_word;
            assign out_valid = w_out_valid;
            assign out_last  = w_out_valid && r_last;
            assign out_lanes = w_out_valid ? r_fill : '0;

            // FILL/FULL sequencing and fill counter.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state <= S_FILL;
                    r_word  <= '0;
                    r_last  <= 1'b0;
                    r_fill  <= '0;
                end else if (w_accept) begin
                    r_word  <= w_word_next;
                    r_fill  <= w_fill_next;
                    r_last  <= in_last;
                    r_state <= ((w_fill_next == CNT_W'(RATIO)) || in_last) ? S_FULL : S_FILL;
                end else if (w_out_xfer) begin
                    r_word  <= '0;
                    r_fill  <= '0;
                    r_last  <= 1'b0;
                    r_state <= S_FILL;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_stream_width_converter.sv
// Testbench for stream_width_converter. Four instances share one clock/reset:
//   0: 64->32 LSB first, 1: 64->32 MSB first, 2: 16->64 LSB first, 3: 32->32.
// Expected output words are produced from the gearbox rules when each input
// word is issued and popped by per-instance monitors on every output transfer.
module tb_stream_width_converter;

  localparam int EW = 73;  // {last, lanes[7:0], data[63:0]}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] in_data;
  logic        in_last;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  out_ready;
  logic [3:0]  rdy_rand;
  logic [3:0]  out_valid;
  logic [3:0]  out_last;

  logic [31:0] dl_data, dm_data, ps_data;
  logic [63:0] up_data;
  logic [1:0]  dl_lanes, dm_lanes;
  logic [2:0]  up_lanes;
  logic [0:0]  ps_lanes;

  logic [63:0] mon_data [4];
  logic [7:0]  mon_lanes [4];

  int n_checks = 0;
  int n_pass = 0;

  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q2[$];
  logic [EW-1:0] exp_q3[$];
  logic [15:0]   up_pend[$];

  stream_width_converter #(.INPUT_WIDTH(64), .OUTPUT_WIDTH(32), .LSB_FIRST(1'b1)) u_down_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid[0]), .in_last(in_last),
    .in_ready(in_ready[0]), .out_data(dl_data), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_last(out_last[0]), .out_lanes(dl_lanes));

  stream_width_converter #(.INPUT_WIDTH(64), .OUTPUT_WIDTH(32), .LSB_FIRST(1'b0)) u_down_msb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid[1]), .in_last(in_last),
    .in_ready(in_ready[1]), .out_data(dm_data), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_last(out_last[1]), .out_lanes(dm_lanes));

  stream_width_converter #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(64), .LSB_FIRST(1'b1)) u_up (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[15:0]), .in_valid(in_valid[2]), .in_last(in_last),
    .in_ready(in_ready[2]), .out_data(up_data), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_last(out_last[2]), .out_lanes(up_lanes));

  stream_width_converter #(.INPUT_WIDTH(32), .OUTPUT_WIDTH(32), .LSB_FIRST(1'b1)) u_pass (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[31:0]), .in_valid(in_valid[3]), .in_last(in_last),
    .in_ready(in_ready[3]), .out_data(ps_data), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .out_last(out_last[3]), .out_lanes(ps_lanes));

  assign mon_data[0]  = {32'd0, dl_data};
  assign mon_data[1]  = {32'd0, dm_data};
  assign mon_data[2]  = up_data;
  assign mon_data[3]  = {32'd0, ps_data};
  assign mon_lanes[0] = {6'd0, dl_lanes};
  assign mon_lanes[1] = {6'd0, dm_lanes};
  assign mon_lanes[2] = {5'd0, up_lanes};
  assign mon_lanes[3] = {7'd0, ps_lanes};

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic void push_exp(int id, logic [EW-1:0] v);
    case (id)
      0: exp_q0.push_back(v);
      1: exp_q1.push_back(v);
      2: exp_q2.push_back(v);
      default: exp_q3.push_back(v);
    endcase
  endfunction

  function automatic logic [EW-1:0] pop_exp(int id);
    case (id)
      0: return exp_q0.pop_front();
      1: return exp_q1.pop_front();
      2: return exp_q2.pop_front();
      default: return exp_q3.pop_front();
    endcase
  endfunction

  function automatic int q_size(int id);
    case (id)
      0: return exp_q0.size();
      1: return exp_q1.size();
      2: return exp_q2.size();
      default: return exp_q3.size();
    endcase
  endfunction

  // Reference model: what each input word must turn into on the output side.
  function automatic void model(int id, logic [63:0] d, logic l);
    logic [63:0] lane;
    logic [63:0] w;
    int sel;
    case (id)
      0, 1: begin
        // Two 32-bit lanes; instance 0 sends the low half first, 1 the high half.
        for (int i = 0; i < 2; i++) begin
          sel = (id == 0) ? i : 1 - i;
          lane = d >> (32 * sel);
          push_exp(id, {l && (i == 1), 8'd1, 32'd0, lane[31:0]});
        end
      end
      2: begin
        // Collect 16-bit beats; a word closes at four beats or on last.
        up_pend.push_back(d[15:0]);
        if (up_pend.size() == 4 || l) begin
          w = '0;
          for (int j = 0; j < up_pend.size(); j++) w = w | (64'(up_pend[j]) << (16 * j));
          push_exp(2, {l, 8'(up_pend.size()), w});
          up_pend.delete();
        end
      end
      default: push_exp(3, {l, 8'd1, 32'd0, d[31:0]});
    endcase
  endfunction

  // Monitor: pops on each output transfer and checks hold-while-stalled.
  task automatic monitor(input int id);
    logic hold_v;
    logic [EW-1:0] held, cur, e;
    hold_v = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      cur = {out_last[id], mon_lanes[id], mon_data[id]};
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          chk($sformatf("hold_valid%0d", id), out_valid[id], 1);
          chk($sformatf("hold_word%0d", id), cur, held);
        end
        if (out_valid[id] && out_ready[id]) begin
          if (q_size(id) == 0) begin
            chk($sformatf("unexpected_out%0d", id), cur, 0);
          end else begin
            e = pop_exp(id);
            chk($sformatf("out%0d", id), cur, e);
          end
          hold_v = 1'b0;
        end else if (out_valid[id]) begin
          hold_v = 1'b1;
          held = cur;
        end else begin
          hold_v = 1'b0;
        end
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic [63:0] d, input logic l);
    int n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_data = d;
    in_last = l;
    in_valid[id] = 1'b1;
    model(id, d, l);
    while (!acc) begin
      @(negedge clk);
      acc = in_ready[id];
      n++;
      if (!acc && n > 300) begin
        chk($sformatf("accept_timeout%0d", id), in_ready[id], 1);
        acc = 1'b1;
      end
      step();
    end
    in_valid[id] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_size(0) + q_size(1) + q_size(2) + q_size(3)) != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    step();
  endtask

  task automatic chk_reset_state(input string tag);
    for (int id = 0; id < 4; id++) begin
      chk($sformatf("%s_valid%0d", tag, id), out_valid[id], 0);
      chk($sformatf("%s_data%0d", tag, id), mon_data[id], 0);
      chk($sformatf("%s_last%0d", tag, id), out_last[id], 0);
      chk($sformatf("%s_lanes%0d", tag, id), mon_lanes[id], 0);
      chk($sformatf("%s_ready%0d", tag, id), in_ready[id], 0);
    end
  endtask

  // Randomised consumer back-pressure for instances flagged in rdy_rand.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (rdy_rand[i]) out_ready[i] = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    fork
      monitor(0);
      monitor(1);
      monitor(2);
      monitor(3);
    join_none
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    in_data = '0;
    in_last = 1'b0;
    in_valid = '0;
    out_ready = 4'hF;
    rdy_rand = '0;

    // Reset state
    #22;
    chk_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_reset", in_ready, 4'hF);
    step();

    // 64->32 LSB first, latency 1
    chk("t1_idle_valid", out_valid[0], 0);
    drive(0, 64'h11112222_33334444, 1'b1);
    @(negedge clk);
    chk("t1_latency", out_valid[0], 1);
    chk("t1_first_lane", dl_data, 32'h33334444);
    step();
    drain();

    // 64->32 MSB first with 3-cycle stall on beat 0
    out_ready[1] = 1'b0;
    drive(1, 64'h11112222_33334444, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_stall_valid", out_valid[1], 1);
      chk("t2_stall_data", dm_data, 32'h11112222);
      chk("t2_stall_ready", in_ready[1], 0);
      step();
    end
    out_ready[1] = 1'b1;
    @(negedge clk);
    chk("t2_release_ready", in_ready[1], 0);
    step();
    drain();

    // 64->32 back-to-back words: 8 output beats without a gap
    fork
      begin
        for (int i = 0; i < 4; i++) drive(0, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid[0] && n < 20) begin
          @(negedge clk);
          n++;
        end
        for (int k = 0; k < 8; k++) begin
          chk("t3_continuous_valid", out_valid[0], 1);
          chk("t3_ready_pattern", in_ready[0], (k % 2) == 1);
          if (k < 7) @(negedge clk);
        end
      end
    join
    step();
    drain();

    // 16->64: partial word closed by last, then a full word from lane 0
    drive(2, 64'hAAAA, 1'b0);
    drive(2, 64'hBBBB, 1'b0);
    drive(2, 64'hCCCC, 1'b1);
    @(negedge clk);
    chk("t4_data", up_data, 64'h0000CCCC_BBBBAAAA);
    chk("t4_lanes", up_lanes, 3);
    chk("t4_last", out_last[2], 1);
    step();
    drive(2, 64'hDDDD, 1'b0);
    drive(2, 64'hEEEE, 1'b0);
    drive(2, 64'hFFFF, 1'b0);
    drive(2, 64'h1234, 1'b0);
    drain();

    // 16->64: reset in the middle of a word
    drive(2, 64'h1111, 1'b0);
    drive(2, 64'h2222, 1'b0);
    #3;
    rst_n = 1'b0;
    up_pend.delete();
    #1;
    chk_reset_state("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_ready_back", in_ready[2], 1);
    step();
    for (int i = 1; i <= 4; i++) drive(2, 64'(i), 1'b0);
    @(negedge clk);
    chk("t5_data", up_data, 64'h0004_0003_0002_0001);
    chk("t5_lanes", up_lanes, 4);
    step();
    drain();

    // 32->32: latency 1 then random traffic
    drive(3, 64'hDEADBEEF, 1'b1);
    @(negedge clk);
    chk("t6_latency", out_valid[3], 1);
    chk("t6_lanes", ps_lanes, 1);
    step();
    drain();

    rdy_rand = 4'hF;
    for (int i = 0; i < 40; i++) begin
      drive(3, {32'd0, $urandom}, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) step();
    end
    for (int i = 0; i < 20; i++) begin
      drive(0, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) step();
    end
    for (int i = 0; i < 12; i++) begin
      drive(1, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) step();
    end
    for (int i = 0; i < 40; i++) begin
      drive(2, {48'd0, 16'($urandom)}, ($urandom_range(0, 3) == 0) || (i == 39));
      if ($urandom_range(0, 3) == 0) step();
    end
    rdy_rand = '0;
    out_ready = 4'hF;
    drain();

    for (int id = 0; id < 4; id++) chk($sformatf("final_queue%0d", id), q_size(id), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
